// File: rtl/minicpu_alu_sequencer.sv
// MiniCPU fetch/execute sequencer: owns the PC and the 4x8 register file, fetches
// 16-bit instructions and issues registered operands/opcodes to an external ALU.
module minicpu_alu_sequencer #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [7:0]      alu_op_a,
  output logic [7:0]      alu_op_b,
  output logic [2:0]      alu_op,
  input  logic [7:0]      alu_result,
  input  logic            alu_zero,
  output logic            commit_valid,
  output logic [1:0]      commit_rd,
  output logic [7:0]      commit_data,
  output logic            halted
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd8;

  localparam logic [2:0] ALU_IDLE = 3'b110;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0][7:0] regs_q, regs_d;
  logic [15:0]     instr_q, instr_d;
  logic            zero_q, zero_d;
  logic [7:0]      alu_op_a_q, alu_op_a_d;
  logic [7:0]      alu_op_b_q, alu_op_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            commit_valid_q, commit_valid_d;
  logic [1:0]      commit_rd_q, commit_rd_d;
  logic [7:0]      commit_data_q, commit_data_d;

  logic [3:0]      f_op;
  logic [1:0]      f_rd, f_rs;
  logic [3:0]      x_op;
  logic [1:0]      x_rd;
  logic [7:0]      x_imm;
  logic [PC_W-1:0] pc_inc;

  assign f_op   = imem_rdata[15:12];
  assign f_rd   = imem_rdata[11:10];
  assign f_rs   = imem_rdata[9:8];
  assign x_op   = instr_q[15:12];
  assign x_rd   = instr_q[11:10];
  assign x_imm  = instr_q[7:0];
  assign pc_inc = pc_q + PC_W'(1);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    regs_d         = regs_q;
    instr_d        = instr_q;
    zero_d         = zero_q;
    alu_op_a_d     = alu_op_a_q;
    alu_op_b_d     = alu_op_b_q;
    alu_op_d       = alu_op_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_data_d  = commit_data_q;

    case (state_q)
      ST_BOOT: state_d = ST_FETCH;

      ST_FETCH: begin
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_EXEC;
          // Opcodes 0..5 map one-to-one onto the ALU encoding; everything else idles it.
          if (f_op <= OP_BEQ) begin
            alu_op_d   = f_op[2:0];
            alu_op_a_d = regs_q[f_rd];
            alu_op_b_d = (f_op == OP_SHL || f_op == OP_SHR) ? 8'd0 : regs_q[f_rs];
          end else begin
            alu_op_d   = ALU_IDLE;
            alu_op_a_d = 8'd0;
            alu_op_b_d = 8'd0;
          end
        end
      end

      ST_EXEC: begin
        zero_d  = alu_zero;
        state_d = ST_WB;
        if (x_op <= OP_SHR) begin
          regs_d[x_rd]   = alu_result;
          commit_valid_d = 1'b1;
          commit_rd_d    = x_rd;
          commit_data_d  = alu_result;
        end else if (x_op == OP_LDI) begin
          regs_d[x_rd]   = x_imm;
          commit_valid_d = 1'b1;
          commit_rd_d    = x_rd;
          commit_data_d  = x_imm;
        end
      end

      ST_WB: begin
        alu_op_d   = ALU_IDLE;
        alu_op_a_d = 8'd0;
        alu_op_b_d = 8'd0;
        pc_d       = pc_inc;
        state_d    = ST_FETCH;
        if (x_op == OP_BEQ && zero_q) pc_d = x_imm[PC_W-1:0];
        if (x_op == OP_JMP)           pc_d = x_imm[PC_W-1:0];
        if (x_op == OP_HALT)          state_d = ST_HALT;
      end

      ST_HALT: state_d = ST_HALT;

      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= PC_W'(RESET_PC);
      regs_q         <= '0;
      instr_q        <= '0;
      zero_q         <= 1'b0;
      alu_op_a_q     <= 8'd0;
      alu_op_b_q     <= 8'd0;
      alu_op_q       <= ALU_IDLE;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= 2'd0;
      commit_data_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      regs_q         <= regs_d;
      instr_q        <= instr_d;
      zero_q         <= zero_d;
      alu_op_a_q     <= alu_op_a_d;
      alu_op_b_q     <= alu_op_b_d;
      alu_op_q       <= alu_op_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_data_q  <= commit_data_d;
    end
  end

  assign imem_req     = (state_q == ST_FETCH);
  assign imem_addr    = pc_q;
  assign halted       = (state_q == ST_HALT);
  assign alu_op_a     = alu_op_a_q;
  assign alu_op_b     = alu_op_b_q;
  assign alu_op       = alu_op_q;
  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_data  = commit_data_q;

endmodule

// File: tb/tb_minicpu_alu_sequencer.sv
// Directed testbench for minicpu_alu_sequencer: small programs in a behavioural
// instruction memory, with a behavioural ALU on the other side of the interface.
module tb_minicpu_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid = 1'b1;
  logic [7:0]  alu_op_a, alu_op_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero;
  logic        commit_valid;
  logic [1:0]  commit_rd;
  logic [7:0]  commit_data;
  logic        halted;

  logic [15:0] mem [256];
  int compared = 0;
  int mismatched = 0;

  minicpu_alu_sequencer #(.PC_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_data(commit_data), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  // Behavioural ALU standing in for the real one.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_op_a + alu_op_b;
      3'b001:  alu_result = alu_op_a - alu_op_b;
      3'b010:  alu_result = alu_op_a * alu_op_b;
      3'b011:  alu_result = alu_op_a << 1;
      3'b100:  alu_result = alu_op_a >> 1;
      3'b101:  alu_result = alu_op_a - alu_op_b;
      default: alu_result = 8'd0;
    endcase
    alu_zero = (alu_result == 8'd0);
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int addr, input logic [15:0] word);
    mem[addr] = word;
  endtask

  task automatic clearProgram();
    for (int i = 0; i < 256; i++) mem[i] = 16'h9000;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic waitCommit(output logic [1:0] rd, output logic [7:0] data, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!commit_valid && cycles < 60);
    if (!commit_valid) checkOutput("commit_timeout", 16'd0, 16'd1);
    rd = commit_rd;
    data = commit_data;
  endtask

  task automatic waitFetch(input logic [7:0] addr);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(imem_req && imem_addr == addr) && n < 200);
    if (!(imem_req && imem_addr == addr)) checkOutput("fetch_timeout", {8'd0, imem_addr}, {8'd0, addr});
  endtask

  logic [1:0] rd;
  logic [7:0] data;
  int cyc;
  logic [9:0] wrapExp [8] = '{
    {2'd0, 8'h03}, {2'd1, 8'h05}, {2'd0, 8'hFE}, {2'd2, 8'h10},
    {2'd3, 8'h10}, {2'd2, 8'h00}, {2'd1, 8'h81}, {2'd1, 8'h02}
  };

  initial begin
    // Basic program with back-to-back fetches.
    clearProgram();
    applyStimulus(0, 16'h6005);
    applyStimulus(1, 16'h6403);
    applyStimulus(2, 16'h0100);
    applyStimulus(3, 16'h8000);
    applyReset();
    checkOutput("rst_req", {15'd0, imem_req}, 16'd0);
    checkOutput("rst_halted", {15'd0, halted}, 16'd0);
    checkOutput("rst_aluop", {13'd0, alu_op}, 16'd6);
    checkOutput("rst_commit", {15'd0, commit_valid}, 16'd0);
    checkOutput("rst_opa", {8'd0, alu_op_a}, 16'd0);
    waitCommit(rd, data, cyc);
    checkOutput("c0", {6'd0, rd, data}, {6'd0, 2'd0, 8'd5});
    waitCommit(rd, data, cyc);
    checkOutput("c1", {6'd0, rd, data}, {6'd0, 2'd1, 8'd3});
    checkOutput("c1_gap", cyc[15:0], 16'd3);
    step();
    checkOutput("add_fetch_addr", {8'd0, imem_addr}, 16'd2);
    step();
    checkOutput("add_aluop", {13'd0, alu_op}, 16'd0);
    checkOutput("add_opa", {8'd0, alu_op_a}, 16'd5);
    checkOutput("add_opb", {8'd0, alu_op_b}, 16'd3);
    step();
    checkOutput("c2_valid", {15'd0, commit_valid}, 16'd1);
    checkOutput("c2", {6'd0, commit_rd, commit_data}, {6'd0, 2'd0, 8'd8});
    step(); step(); step();
    checkOutput("halt_wb_halted", {15'd0, halted}, 16'd0);
    checkOutput("halt_wb_commit", {15'd0, commit_valid}, 16'd0);
    step();
    checkOutput("halted", {15'd0, halted}, 16'd1);
    checkOutput("halted_req", {15'd0, imem_req}, 16'd0);
    step(); step();
    checkOutput("halted_stays", {14'd0, halted, imem_req}, 16'd2);

    // Modulo-256 arithmetic through the ALU.
    clearProgram();
    applyStimulus(0, 16'h6003);
    applyStimulus(1, 16'h6405);
    applyStimulus(2, 16'h1100);
    applyStimulus(3, 16'h6810);
    applyStimulus(4, 16'h6C10);
    applyStimulus(5, 16'h2B00);
    applyStimulus(6, 16'h6481);
    applyStimulus(7, 16'h3400);
    applyStimulus(8, 16'h8000);
    applyReset();
    for (int i = 0; i < 8; i++) begin
      waitCommit(rd, data, cyc);
      checkOutput($sformatf("wrap%0d", i), {6'd0, rd, data}, {6'd0, wrapExp[i]});
    end

    // BEQ taken, then not taken after r1 changes.
    clearProgram();
    applyStimulus(0, 16'h6007);
    applyStimulus(1, 16'h6407);
    applyStimulus(4, 16'h5120);
    applyStimulus(8'h20, 16'h6408);
    applyStimulus(8'h21, 16'h7004);
    applyStimulus(5, 16'h8000);
    applyReset();
    waitFetch(8'h04);
    step();
    checkOutput("beq_aluop", {13'd0, alu_op}, 16'd5);
    checkOutput("beq_ops", {alu_op_a, alu_op_b}, 16'h0707);
    step();
    checkOutput("beq_nocommit", {15'd0, commit_valid}, 16'd0);
    step();
    checkOutput("beq_taken_addr", {8'd0, imem_addr}, 16'h0020);
    waitCommit(rd, data, cyc);
    checkOutput("beq_r1", {6'd0, rd, data}, {6'd0, 2'd1, 8'd8});
    waitFetch(8'h04);
    step();
    checkOutput("beq2_ops", {alu_op_a, alu_op_b}, 16'h0708);
    step();
    checkOutput("beq2_nocommit", {15'd0, commit_valid}, 16'd0);
    step();
    checkOutput("beq_fall_addr", {8'd0, imem_addr}, 16'h0005);

    // Fetch stall, and a valid pulse during EXEC.
    clearProgram();
    applyStimulus(0, 16'h6809);
    applyStimulus(1, 16'h8000);
    imem_valid = 1'b0;
    applyReset();
    waitFetch(8'h00);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stall_req%0d", i), {15'd0, imem_req}, 16'd1);
      checkOutput($sformatf("stall_addr%0d", i), {8'd0, imem_addr}, 16'd0);
      checkOutput($sformatf("stall_commit%0d", i), {15'd0, commit_valid}, 16'd0);
      if (i < 2) step();
    end
    imem_valid = 1'b1;
    step();
    checkOutput("stall_exec_req", {15'd0, imem_req}, 16'd0);
    imem_valid = 1'b0;
    step();
    checkOutput("stall_commit", {5'd0, commit_valid, commit_rd, commit_data}, {5'd0, 1'b1, 2'd2, 8'd9});
    step();
    checkOutput("stall_next_addr", {7'd0, imem_req, imem_addr}, {7'd0, 1'b1, 8'd1});
    step();
    checkOutput("stall_hold", {7'd0, imem_req, imem_addr}, {7'd0, 1'b1, 8'd1});
    imem_valid = 1'b1;

    // PC wraps from 0xFF to 0x00.
    clearProgram();
    applyStimulus(0, 16'h70FF);
    applyReset();
    waitFetch(8'hFF);
    step(); step(); step();
    checkOutput("pc_wrap", {8'd0, imem_addr}, 16'd0);

    // Reset during EXEC of an ADD discards it and clears the registers.
    clearProgram();
    applyStimulus(0, 16'h6005);
    applyStimulus(1, 16'h6403);
    applyStimulus(2, 16'h0100);
    applyReset();
    waitFetch(8'h02);
    step();
    checkOutput("mid_exec_aluop", {13'd0, alu_op}, 16'd0);
    rst_n = 1'b0;
    applyStimulus(0, 16'h0100);
    applyStimulus(1, 16'h8000);
    step();
    rst_n = 1'b1;
    checkOutput("mid_rst_commit", {15'd0, commit_valid}, 16'd0);
    checkOutput("mid_rst_req", {15'd0, imem_req}, 16'd0);
    checkOutput("mid_rst_aluop", {13'd0, alu_op}, 16'd6);
    step();
    checkOutput("mid_boot_fetch", {7'd0, imem_req, imem_addr}, {7'd0, 1'b1, 8'd0});
    step();
    checkOutput("mid_regs_zero", {alu_op_a, alu_op_b}, 16'h0000);
    step();
    checkOutput("mid_commit", {5'd0, commit_valid, commit_rd, commit_data}, {5'd0, 1'b1, 2'd0, 8'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
